vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
//  Generates 640x480@60Hz VGA timing from clk_50MHz for the top-level main block.
//  Drives hs_vga/vs_vga straight to the connector.
//  Gives the pixel renderer (RED/GREEN/BLUE) aligned pixel coordinates, a visible-area flag and frame/line strobes.
//  Sits directly upstream of the renderer; every pixel decision in main is gated by its outputs.
// PARAMETERS
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BACK     48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_VISIBLE  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BACK     33   vertical back porch, lines (V_TOTAL = 525)
//  CLK_DIV    2    clk_50MHz cycles per pixel (25 MHz pixel rate)
//  SYNC_ACT   0    sync active level (0 = active-low, VGA standard)
// PORTS
//  clk_50MHz    in   1   system clock, single clock domain
//  reset        in   1   asynchronous, active-high reset
//  hs_vga       out  1   horizontal sync, registered
//  vs_vga       out  1   vertical sync, registered
//  pix_en       out  1   one-clk strobe, high once per pixel period
//  video_on     out  1   1 while (pix_x,pix_y) is inside 640x480
//  pix_x        out  10  horizontal count 0..799 (raw; gate with video_on)
//  pix_y        out  10  vertical count 0..524 (raw)
//  line_start   out  1   one-clk pulse at pixel (0,y) of every line
//  frame_start  out  1   one-clk pulse at pixel (0,0)
// BEHAVIOUR
//  - Stage 0 (counters):
//    - div_cnt counts 0..CLK_DIV-1; pix_tick = (div_cnt==CLK_DIV-1).
//    - On pix_tick, h_cnt advances; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
//    - v_cnt wraps V_TOTAL-1 -> 0 on that same tick.
//  - Stage 1 (output regs): every clk, decodes the stage-0 values.
//    - Fixed 1-clk latency; all outputs are mutually aligned.
//    - Outputs hold constant for CLK_DIV clks per pixel.
//  - hs_vga = SYNC_ACT when h in [656,751], else ~SYNC_ACT.
//  - vs_vga = SYNC_ACT when v in [490,491], else ~SYNC_ACT.
//  - video_on = (h<640)&&(v<480); pix_x=h; pix_y=v.
//  - pix_en = 1 in the first clk of each pixel period (stage-0 div_cnt==0).
//  - line_start = pix_en && h==0; frame_start = pix_en && h==0 && v==0.
//  - Reset (async assert, any time incl. mid-frame):
//    - div_cnt=h_cnt=v_cnt=0.
//    - hs_vga=vs_vga=~SYNC_ACT; video_on=0; pix_en=line_start=frame_start=0; pix_x=pix_y=0.
//  - First clk edge after reset release loads the (0,0) decode: pix_en=1, line_start=1, frame_start=1, video_on=1.
//  - Simultaneous h and v wrap at (799,524) -> (0,0) in one tick; there is no dead pixel.
//  - Periods are exact:
//    - line = 800*CLK_DIV = 1600 clks;
//    - frame = 525 lines = 840000 clks;
//    - hs low 192 clks; vs low 2 lines = 3200 clks.
//  - No handshake; consumers sample on pix_en; outputs never stall.
// STRUCTURE
//  - Shared header vga_params.vh holds:
//    - the timing constants;
//    - derived H_TOTAL, V_TOTAL, HS_START/HS_END, VS_START/VS_END;
//    - coordinate width 10.
//  - main and this block both `include it.
//  - One natural sub-module: mod_counter (params MOD, W; ports clk_50MHz, reset, en, count, wrap).
//    - Instantiated for h (MOD=800) and v (MOD=525).
//    - The v instance's en = h wrap && pix_tick.
//  - div_cnt and the stage-1 decode stay inline.
// TESTING
//  - Release reset, run 2 frames:
//    - frame_start pulses exactly every 840000 clks;
//    - line_start every 1600 clks;
//    - first pulse 1 clk after release.
//  - Line sweep:
//    - hs_vga falls when pix_x becomes 656 and rises when pix_x becomes 752;
//    - video_on falls at pix_x=640 and rises at pix_x=0.
//  - Frame sweep:
//    - vs_vga low only for pix_y 490..491;
//    - video_on 0 for every pixel with pix_y>=480;
//    - count of video_on&&pix_en per frame = 307200.
//  - Wrap corner: at (799,524) the next pix_en shows (0,0) with frame_start=1, video_on=1, hs=vs=1.
//  - Reset mid-frame at pix_y=200 (inside vs-low window at y=490 too):
//    - all outputs reach reset values with no clk edge;
//    - after release, the sequence restarts at (0,0).
//  - Parameter override (H_VISIBLE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_* similarly, CLK_DIV=1):
//    - line = 14 clks;
//    - pix_en constantly 1;
//    - sync windows move accordingly.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants and types for the VGA timing block.
//  - Default 640x480@60Hz timing (25 MHz pixel rate from a 50 MHz clock).
//  - vga_out_t bundles the registered stage-1 decode so it moves as one value.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 2;

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               pix_en;
    logic               video_on;
    logic               line_start;
    logic               frame_start;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
  } vga_out_t;

  // Counter width for a modulus, never below one bit (CLK_DIV=1 still needs a reg).
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: timing outputs from vga_timing to the connector and renderer.
//  master: driven by vga_timing.  slave: consumed by the renderer / pins.
//  hs_vga, vs_vga      sync pulses (level set by SYNC_ACT)
//  pix_en              one-clk strobe per pixel period
//  video_on            (pix_x,pix_y) inside the visible area
//  pix_x, pix_y        raw counters
//  line_start          first clk of pixel (0,y)
//  frame_start         first clk of pixel (0,0)
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic               hs_vga;
  logic               vs_vga;
  logic               pix_en;
  logic               video_on;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               line_start;
  logic               frame_start;

  modport master (
    output hs_vga, vs_vga, pix_en, video_on, pix_x, pix_y, line_start, frame_start
  );

  modport slave (
    input hs_vga, vs_vga, pix_en, video_on, pix_x, pix_y, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_mod_counter.sv
// mod_counter: modulo-MOD up counter with enable.
//  clk_50MHz  in  clock
//  reset      in  async active-high reset, clears count
//  en         in  advance by one when high
//  count      out current value 0..MOD-1
//  wrap       out count is at MOD-1 (terminal count, not qualified by en)
module mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk_50MHz,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = (count == W'(MOD - 1));

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset)   count <= '0;
    else if (en) count <= wrap ? '0 : count + W'(1);
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA sync/coordinate generator.
//  clk_50MHz  in  system clock
//  reset      in  async active-high reset
//  vga        out vga_timing_if.master (syncs, pixel strobe, coordinates, strobes)
// Stage 0: clock divider plus h/v counters. Stage 1: registered decode of the
// stage-0 state, so every output sits exactly one clk behind the counters and
// all outputs are mutually aligned.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter bit SYNC_ACT  = 1'b0
) (
  input  logic         clk_50MHz,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = cnt_w(CLK_DIV);

  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic               pix_tick;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap;
  logic               v_wrap_unused;  // v terminal count has no consumer
  vga_out_t           nxt;
  vga_out_t           out_q;

  // ---- stage 0: counters ----
  assign pix_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= pix_tick ? '0 : div_cnt + DIV_W'(1);
  end

  mod_counter #(.MOD(H_TOTAL), .W(COORD_W)) u_h_cnt (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .en        (pix_tick),
    .count     (h_cnt),
    .wrap      (h_wrap)
  );

  // v steps on the same tick that h wraps, so (799,524)->(0,0) happens in one tick.
  mod_counter #(.MOD(V_TOTAL), .W(COORD_W)) u_v_cnt (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .en        (pix_tick && h_wrap),
    .count     (v_cnt),
    .wrap      (v_wrap_unused)
  );

  // ---- stage 1: decode ----
  always_comb begin
    nxt             = '0;
    nxt.hs          = (h_cnt >= HS_START && h_cnt <= HS_END) ? SYNC_ACT : ~SYNC_ACT;
    nxt.vs          = (v_cnt >= VS_START && v_cnt <= VS_END) ? SYNC_ACT : ~SYNC_ACT;
    nxt.pix_en      = (div_cnt == '0);
    nxt.video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    nxt.line_start  = nxt.pix_en && (h_cnt == '0);
    nxt.frame_start = nxt.line_start && (v_cnt == '0);
    nxt.pix_x       = h_cnt;
    nxt.pix_y       = v_cnt;
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      out_q.hs <= ~SYNC_ACT;
      out_q.vs <= ~SYNC_ACT;
    end else begin
      out_q    <= nxt;
    end
  end

  assign vga.hs_vga      = out_q.hs;
  assign vga.vs_vga      = out_q.vs;
  assign vga.pix_en      = out_q.pix_en;
  assign vga.video_on    = out_q.video_on;
  assign vga.line_start  = out_q.line_start;
  assign vga.frame_start = out_q.frame_start;
  assign vga.pix_x       = out_q.pix_x;
  assign vga.pix_y       = out_q.pix_y;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: two instances share one clock.
//  dut_a: default 640x480 timing, CLK_DIV=2 (line-level behaviour, vector table).
//  dut_b: 8/2/2/2 x 8/2/2/2, CLK_DIV=1 (14x14 frame, frame-level behaviour).
// Both are tracked by a scoreboard whose model derives (h,v,div) from a single
// elapsed-clk count rather than from cascaded counters.
module tb_vga_timing;
  import vga_timing_pkg::*;

  localparam int SB_HT = 14, SB_VT = 14;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #10 clk = ~clk;

  vga_timing_if if_a();
  vga_timing_if if_b();

  vga_timing dut_a (.clk_50MHz(clk), .reset(rst_a), .vga(if_a));

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(1)
  ) dut_b (.clk_50MHz(clk), .reset(rst_b), .vga(if_b));

  vga_out_t out_a, out_b;
  assign out_a = {if_a.hs_vga, if_a.vs_vga, if_a.pix_en, if_a.video_on,
                  if_a.line_start, if_a.frame_start, if_a.pix_x, if_a.pix_y};
  assign out_b = {if_b.hs_vga, if_b.vs_vga, if_b.pix_en, if_b.video_on,
                  if_b.line_start, if_b.frame_start, if_b.pix_x, if_b.pix_y};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vga_out_t mk(input logic hs, vs, en, von, ls, fs, input int x, y);
    mk = {hs, vs, en, von, ls, fs, COORD_W'(x), COORD_W'(y)};
  endfunction

  // Expected outputs for the s-th clk after reset release (active-low syncs).
  function automatic vga_out_t model(input int s, cd, hv, hf, hsy, hb, vv, vf, vsy, vb);
    int ht, vt, d, p, h, v;
    logic en;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    d  = s % cd;
    p  = s / cd;
    h  = p % ht;
    v  = (p / ht) % vt;
    en = (d == 0);
    model = mk(!(h >= hv + hf && h < hv + hf + hsy),
               !(v >= vv + vf && v < vv + vf + vsy),
               en, (h < hv) && (v < vv), en && h == 0, en && h == 0 && v == 0, h, v);
  endfunction

  // ---- scoreboards: push at the edge, compare on the following negedge ----
  vga_out_t q_a[$];
  vga_out_t q_b[$];
  int s_a, s_b, cyc_a;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      s_a   <= 0;
      cyc_a <= 0;
      q_a.delete();
    end else begin
      q_a.push_back(model(s_a, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      s_a   <= (s_a + 1) % (2 * 800 * 525);
      cyc_a <= cyc_a + 1;
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      s_b <= 0;
      q_b.delete();
    end else begin
      q_b.push_back(model(s_b, 1, 8, 2, 2, 2, 8, 2, 2, 2));
      s_b <= (s_b + 1) % (SB_HT * SB_VT);
    end
  end

  always @(negedge clk) begin
    if (!rst_a && q_a.size() > 0) chk("sb_a", out_a, q_a.pop_front());
    if (!rst_b && q_b.size() > 0) chk("sb_b", out_b, q_b.pop_front());
  end

  // ---- hand-derived vectors for dut_a: n = clk edges since release ----
  typedef struct {
    int       n;
    vga_out_t exp;
  } vec_t;

  vec_t     tbl[11];
  vga_out_t rst_v;

  // Wait (on negedges) until the chosen DUT shows (x,y); y<0 means any line.
  task automatic wait_xy(input bit use_b, input int x, input int y, input int limit);
    vga_out_t o;
    for (int k = 0; k < limit; k++) begin
      o = use_b ? out_b : out_a;
      if (o.pix_x == COORD_W'(x) && (y < 0 || o.pix_y == COORD_W'(y))) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_xy: timed out waiting for x=%0d y=%0d", x, y);
  endtask

  int en_n, ve_n, vsl_n, hsl_n, ls_n, ls_bad, vs_bad, von_bad, last_ls;

  initial begin
    rst_v   = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[0]  = '{1,    mk(1, 1, 1, 1, 1, 1, 0,   0)};
    tbl[1]  = '{2,    mk(1, 1, 0, 1, 0, 0, 0,   0)};
    tbl[2]  = '{1279, mk(1, 1, 1, 1, 0, 0, 639, 0)};
    tbl[3]  = '{1281, mk(1, 1, 1, 0, 0, 0, 640, 0)};
    tbl[4]  = '{1312, mk(1, 1, 0, 0, 0, 0, 655, 0)};
    tbl[5]  = '{1313, mk(0, 1, 1, 0, 0, 0, 656, 0)};
    tbl[6]  = '{1504, mk(0, 1, 0, 0, 0, 0, 751, 0)};
    tbl[7]  = '{1505, mk(1, 1, 1, 0, 0, 0, 752, 0)};
    tbl[8]  = '{1600, mk(1, 1, 0, 0, 0, 0, 799, 0)};
    tbl[9]  = '{1601, mk(1, 1, 1, 1, 1, 0, 0,   1)};
    tbl[10] = '{3201, mk(1, 1, 1, 1, 1, 0, 0,   2)};

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_a", out_a, rst_v);
    chk("reset_b", out_b, rst_v);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 5000 && cyc_a < tbl[i].n; k++) @(negedge clk);
      chk($sformatf("vec_a[%0d] n=%0d", i, tbl[i].n), out_a, tbl[i].exp);
    end

    // dut_b: two full frames of period and window statistics
    wait_xy(1'b1, 0, 0, 400);
    for (int f = 0; f < 2; f++) begin
      en_n = 0; ve_n = 0; vsl_n = 0; hsl_n = 0; ls_n = 0;
      ls_bad = 0; vs_bad = 0; von_bad = 0; last_ls = 0;
      for (int c = 0; c < SB_HT * SB_VT; c++) begin
        en_n  += int'(out_b.pix_en);
        ve_n  += int'(out_b.video_on && out_b.pix_en);
        vsl_n += int'(!out_b.vs);
        hsl_n += int'(!out_b.hs);
        if (out_b.line_start) begin
          if (ls_n > 0 && c - last_ls != SB_HT) ls_bad++;
          last_ls = c;
          ls_n++;
        end
        if (!out_b.vs && (out_b.pix_y < 10 || out_b.pix_y > 11)) vs_bad++;
        if (out_b.video_on && out_b.pix_y >= 8) von_bad++;
        @(negedge clk);
      end
      chk("b_frame_period", out_b.frame_start, 1'b1);
      chk("b_pix_en_always", en_n, 196);
      chk("b_visible_pixels", ve_n, 64);
      chk("b_vs_low_clks", vsl_n, 28);
      chk("b_hs_low_clks", hsl_n, 28);
      chk("b_lines", ls_n, 14);
      chk("b_line_period", ls_bad, 0);
      chk("b_vs_window", vs_bad, 0);
      chk("b_video_rows", von_bad, 0);
    end

    // wrap corner (13,13) -> (0,0)
    wait_xy(1'b1, 13, 13, 400);
    @(negedge clk);
    chk("b_wrap", out_b, mk(1, 1, 1, 1, 1, 1, 0, 0));

    // async reset mid-frame, then inside the vs-low window
    wait_xy(1'b1, 3, 5, 400);
    #3 rst_b = 1'b1;
    #1 chk("b_async_rst_y5", out_b, rst_v);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_restart_y5", out_b, mk(1, 1, 1, 1, 1, 1, 0, 0));

    wait_xy(1'b1, 4, 10, 400);
    chk("b_vs_low_before_rst", out_b.vs, 1'b0);
    #3 rst_b = 1'b1;
    #1 chk("b_async_rst_y10", out_b, rst_v);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_restart_y10", out_b, mk(1, 1, 1, 1, 1, 1, 0, 0));

    // dut_a: async reset while hs is active
    wait_xy(1'b0, 700, -1, 2000);
    chk("a_hs_low_before_rst", out_a.hs, 1'b0);
    #3 rst_a = 1'b1;
    #1 chk("a_async_rst", out_a, rst_v);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_restart", out_a, mk(1, 1, 1, 1, 1, 1, 0, 0));
    @(negedge clk);
    chk("a_restart_2nd_clk", out_a, mk(1, 1, 0, 1, 0, 0, 0, 0));
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
